// File: rtl/issue_queue_decoder_pkg.sv
// Shared RV32I decode constants, issue-type codes and immediate extraction helpers
// for the instruction issue queue.
package issue_queue_decoder_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    ROB_RD = 2'd0,
    ROB_LD = 2'd1,
    ROB_ST = 2'd2,
    ROB_BR = 2'd3
  } rob_type_e;

  typedef enum logic [1:0] {
    RS_CLS_OP    = 2'd0,
    RS_CLS_OPIMM = 2'd1,
    RS_CLS_BR    = 2'd2,
    RS_CLS_NONE  = 2'd3
  } rs_class_e;

  // alt carries funct7[5]: SUB/SRA for OP, SRAI for OP-IMM.
  typedef struct packed {
    rs_class_e  cls;
    logic       alt;
    logic [2:0] funct3;
  } rs_type_t;

  typedef logic [3:0] lsb_type_t;  // {opcode[5], funct3}

  function automatic logic [31:0] imm_i(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] ins);
    return {ins[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/issue_queue_decoder_if.sv
// Issue bus from the decoder to ROB/RS/LSB: per-target strobes plus the shared payload.
interface issue_queue_decoder_if
  import issue_queue_decoder_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ROB_IDX_W = 5
) ();
  logic                 rob_valid;
  logic                 rs_valid;
  logic                 lsb_valid;
  rob_type_e            iss_rob_type;
  logic                 iss_rob_ready;
  logic [XLEN-1:0]      iss_rob_value;
  logic [4:0]           iss_rd;
  logic [XLEN-1:0]      iss_pc;
  logic [XLEN-1:0]      iss_jp_pc;
  rs_type_t             iss_rs_type;
  lsb_type_t            iss_lsb_type;
  logic [XLEN-1:0]      iss_v1;
  logic [XLEN-1:0]      iss_v2;
  logic [ROB_IDX_W-1:0] iss_q1;
  logic [ROB_IDX_W-1:0] iss_q2;
  logic                 iss_dep1;
  logic                 iss_dep2;
  logic [XLEN-1:0]      iss_imm;
  logic [ROB_IDX_W-1:0] iss_rob_id;

  modport master (
    output rob_valid, rs_valid, lsb_valid, iss_rob_type, iss_rob_ready, iss_rob_value,
           iss_rd, iss_pc, iss_jp_pc, iss_rs_type, iss_lsb_type, iss_v1, iss_v2,
           iss_q1, iss_q2, iss_dep1, iss_dep2, iss_imm, iss_rob_id
  );

  modport slave (
    input rob_valid, rs_valid, lsb_valid, iss_rob_type, iss_rob_ready, iss_rob_value,
          iss_rd, iss_pc, iss_jp_pc, iss_rs_type, iss_lsb_type, iss_v1, iss_v2,
          iss_q1, iss_q2, iss_dep1, iss_dep2, iss_imm, iss_rob_id
  );
endinterface

// File: rtl/issue_queue_decoder_insn_fifo.sv
// Power-of-two instruction FIFO with push/pop/clear; head is the oldest entry.
module issue_queue_decoder_insn_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; count/empty guarantee stale entries are never consumed.
  always_ff @(posedge clk_in) begin
    if (push && !clear) mem_q[wr_ptr_q] <= wdata;
  end

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/issue_queue_decoder.sv
// Buffers fetched RV32I instructions, decodes the FIFO head and issues one per cycle
// to ROB/RS/LSB; a JALR holds the head until rs1 is ready, then redirects fetch.
module issue_queue_decoder
  import issue_queue_decoder_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ROB_IDX_W = 5,
  parameter int XLEN      = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rdy_in,
  input  logic                 flush_in,
  input  logic                 fetch_valid,
  input  logic [31:0]          fetch_ins,
  input  logic [XLEN-1:0]      fetch_pc,
  input  logic [XLEN-1:0]      fetch_pred_pc,
  output logic                 fetch_ready,
  output logic                 redirect_valid,
  output logic [XLEN-1:0]      redirect_pc,
  input  logic                 rob_full_in,
  input  logic                 rs_full_in,
  input  logic                 lsb_full_in,
  input  logic [ROB_IDX_W-1:0] rob_tail_in,
  output logic [4:0]           reg_id1,
  output logic [4:0]           reg_id2,
  input  logic [XLEN-1:0]      reg_val1,
  input  logic [XLEN-1:0]      reg_val2,
  input  logic                 reg_dep1,
  input  logic                 reg_dep2,
  input  logic [ROB_IDX_W-1:0] reg_tag1,
  input  logic [ROB_IDX_W-1:0] reg_tag2,
  issue_queue_decoder_if.master iss
);
  localparam int EW = 32 + 2 * XLEN;
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_JWAIT = 1'b1;

  typedef struct packed {
    rob_type_e            rob_type;
    logic                 rob_ready;
    logic [XLEN-1:0]      rob_value;
    logic [4:0]           rd;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      jp_pc;
    rs_type_t             rs_type;
    lsb_type_t            lsb_type;
    logic [XLEN-1:0]      v1;
    logic [XLEN-1:0]      v2;
    logic [ROB_IDX_W-1:0] q1;
    logic [ROB_IDX_W-1:0] q2;
    logic                 dep1;
    logic                 dep2;
    logic [XLEN-1:0]      imm;
    logic [ROB_IDX_W-1:0] rob_id;
  } iss_data_t;

  logic            push, pop, clear, full, empty;
  logic [EW-1:0]   head;
  logic [31:0]     ins;
  logic [XLEN-1:0] h_pc, h_pred;
  logic [6:0]      opcode;
  logic [2:0]      f3;

  issue_queue_decoder_insn_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_fifo (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .push     (push),
    .pop      (pop),
    .clear    (clear),
    .wdata    ({fetch_ins, fetch_pc, fetch_pred_pc}),
    .full     (full),
    .empty    (empty),
    .head     (head)
  );

  assign {ins, h_pc, h_pred} = head;
  assign opcode  = ins[6:0];
  assign f3      = ins[14:12];
  assign reg_id1 = empty ? 5'd0 : ins[19:15];
  assign reg_id2 = empty ? 5'd0 : ins[24:20];

  logic            is_rs, is_lsb, is_jalr, uses_rs1, uses_rs2, rob_ready;
  rob_type_e       rob_type;
  rs_type_t        rs_type;
  logic [4:0]      dec_rd;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_x, rob_value;

  always_comb begin
    is_rs     = 1'b0;
    is_lsb    = 1'b0;
    is_jalr   = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    rob_ready = 1'b0;
    rob_type  = ROB_RD;
    rs_type   = '{cls: RS_CLS_NONE, alt: 1'b0, funct3: 3'd0};
    dec_rd    = ins[11:7];
    imm32     = '0;
    case (opcode)
      OPC_LUI:    begin rob_ready = 1'b1; imm32 = imm_u(ins); end
      OPC_AUIPC:  begin rob_ready = 1'b1; imm32 = imm_u(ins); end
      OPC_JAL:    begin rob_ready = 1'b1; imm32 = imm_j(ins); end
      OPC_JALR:   begin rob_ready = 1'b1; is_jalr = 1'b1; uses_rs1 = 1'b1; imm32 = imm_i(ins); end
      OPC_BRANCH: begin
        is_rs = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; rob_type = ROB_BR; dec_rd = 5'd0;
        imm32 = imm_b(ins); rs_type = '{cls: RS_CLS_BR, alt: 1'b0, funct3: f3};
      end
      OPC_LOAD:   begin is_lsb = 1'b1; uses_rs1 = 1'b1; rob_type = ROB_LD; imm32 = imm_i(ins); end
      OPC_STORE:  begin
        is_lsb = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; rob_type = ROB_ST; dec_rd = 5'd0;
        imm32 = imm_s(ins);
      end
      OPC_OPIMM:  begin
        is_rs = 1'b1; uses_rs1 = 1'b1;
        // Shift-immediates carry a zero-extended shamt; funct7[5] only matters for SRAI.
        imm32 = (f3 == 3'b001 || f3 == 3'b101) ? {27'd0, ins[24:20]} : imm_i(ins);
        rs_type = '{cls: RS_CLS_OPIMM, alt: (f3 == 3'b101) && ins[30], funct3: f3};
      end
      OPC_OP:     begin
        is_rs = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        rs_type = '{cls: RS_CLS_OP, alt: ins[30], funct3: f3};
      end
      default:    begin rob_ready = 1'b1; dec_rd = 5'd0; end
    endcase
  end

  assign imm_x = XLEN'($signed(imm32));
  assign rob_value = (opcode == OPC_LUI)   ? imm_x :
                     (opcode == OPC_AUIPC) ? h_pc + imm_x :
                     (is_jalr || opcode == OPC_JAL) ? h_pc + XLEN'(4) : '0;

  logic [0:0] state_q, state_d;
  logic       jalr_blocked, can_issue, issue;

  // JWAIT only ever holds a JALR head, so the rs1-dependency term alone gates it and
  // lets the instruction issue in the very cycle its operand becomes ready.
  assign jalr_blocked = is_jalr && reg_dep1;
  assign can_issue    = !empty && !rob_full_in && (!is_lsb || !lsb_full_in)
                        && (!is_rs || !rs_full_in) && !jalr_blocked;
  assign issue        = rdy_in && !flush_in && can_issue;
  assign clear        = rdy_in && (flush_in || (issue && is_jalr));
  assign pop          = issue;
  assign fetch_ready  = rst_n_in && rdy_in && !full;
  assign push         = fetch_valid && fetch_ready && !clear;

  always_comb begin
    state_d = state_q;
    if (rdy_in) begin
      if (flush_in)                                         state_d = ST_RUN;
      else if (state_q == ST_RUN && !empty && jalr_blocked) state_d = ST_JWAIT;
      else if (state_q == ST_JWAIT && !reg_dep1)            state_d = ST_RUN;
    end
  end

  iss_data_t       iss_q, iss_d;
  logic            rob_valid_q, rob_valid_d, rs_valid_q, rs_valid_d, lsb_valid_q, lsb_valid_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  always_comb begin
    iss_d            = iss_q;
    rob_valid_d      = 1'b0;
    rs_valid_d       = 1'b0;
    lsb_valid_d      = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    if (issue) begin
      rob_valid_d     = 1'b1;
      rs_valid_d      = is_rs;
      lsb_valid_d     = is_lsb;
      iss_d.rob_type  = rob_type;
      iss_d.rob_ready = rob_ready;
      iss_d.rob_value = rob_value;
      iss_d.rd        = dec_rd;
      iss_d.pc        = h_pc;
      iss_d.jp_pc     = h_pred;
      iss_d.rs_type   = rs_type;
      iss_d.lsb_type  = {opcode[5], f3};
      iss_d.v1        = uses_rs1 ? reg_val1 : '0;
      iss_d.v2        = uses_rs2 ? reg_val2 : '0;
      iss_d.q1        = reg_tag1;
      iss_d.q2        = reg_tag2;
      iss_d.dep1      = uses_rs1 && reg_dep1;
      iss_d.dep2      = uses_rs2 && reg_dep2;
      iss_d.imm       = imm_x;
      iss_d.rob_id    = rob_tail_in;
      if (is_jalr) begin
        redirect_valid_d = 1'b1;
        redirect_pc_d    = (reg_val1 + imm_x) & ~XLEN'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q          <= ST_RUN;
      iss_q            <= '0;
      rob_valid_q      <= 1'b0;
      rs_valid_q       <= 1'b0;
      lsb_valid_q      <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      iss_q            <= iss_d;
      rob_valid_q      <= rob_valid_d;
      rs_valid_q       <= rs_valid_d;
      lsb_valid_q      <= lsb_valid_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign redirect_valid    = redirect_valid_q;
  assign redirect_pc       = redirect_pc_q;
  assign iss.rob_valid     = rob_valid_q;
  assign iss.rs_valid      = rs_valid_q;
  assign iss.lsb_valid     = lsb_valid_q;
  assign iss.iss_rob_type  = iss_q.rob_type;
  assign iss.iss_rob_ready = iss_q.rob_ready;
  assign iss.iss_rob_value = iss_q.rob_value;
  assign iss.iss_rd        = iss_q.rd;
  assign iss.iss_pc        = iss_q.pc;
  assign iss.iss_jp_pc     = iss_q.jp_pc;
  assign iss.iss_rs_type   = iss_q.rs_type;
  assign iss.iss_lsb_type  = iss_q.lsb_type;
  assign iss.iss_v1        = iss_q.v1;
  assign iss.iss_v2        = iss_q.v2;
  assign iss.iss_q1        = iss_q.q1;
  assign iss.iss_q2        = iss_q.q2;
  assign iss.iss_dep1      = iss_q.dep1;
  assign iss.iss_dep2      = iss_q.dep2;
  assign iss.iss_imm       = iss_q.imm;
  assign iss.iss_rob_id    = iss_q.rob_id;

endmodule

// File: tb/tb_issue_queue_decoder.sv
// Directed bench for issue_queue_decoder: each task drives one scenario and checks inline.
module tb_issue_queue_decoder;
  import issue_queue_decoder_pkg::*;

  localparam int XLEN = 32;
  localparam int RW   = 5;

  localparam logic [31:0] INS_ADDI_M5 = 32'hFFB00093;  // addi x1,x0,-5
  localparam logic [31:0] INS_JALR    = 32'h00828067;  // jalr x0,8(x5)
  localparam logic [31:0] INS_SW      = 32'h0021A623;  // sw x2,12(x3)
  localparam logic [31:0] INS_SRAI    = 32'h40315093;  // srai x1,x2,3
  localparam logic [31:0] INS_LUI     = 32'h123451B7;  // lui x3,0x12345
  localparam logic [31:0] INS_UNKNOWN = 32'h0000008B;  // custom-0 opcode, rd field = 1

  logic            clk_in = 1'b0;
  logic            rst_n_in, rdy_in, flush_in, fetch_valid;
  logic [31:0]     fetch_ins;
  logic [XLEN-1:0] fetch_pc, fetch_pred_pc, redirect_pc, reg_val1, reg_val2;
  logic            fetch_ready, redirect_valid, rob_full_in, rs_full_in, lsb_full_in;
  logic [RW-1:0]   rob_tail_in, reg_tag1, reg_tag2;
  logic [4:0]      reg_id1, reg_id2;
  logic            reg_dep1, reg_dep2;

  int pass_cnt  = 0;
  int total_cnt = 0;

  issue_queue_decoder_if #(.XLEN(XLEN), .ROB_IDX_W(RW)) iss ();

  issue_queue_decoder #(.DEPTH(4), .ROB_IDX_W(RW), .XLEN(XLEN)) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .rdy_in         (rdy_in),
    .flush_in       (flush_in),
    .fetch_valid    (fetch_valid),
    .fetch_ins      (fetch_ins),
    .fetch_pc       (fetch_pc),
    .fetch_pred_pc  (fetch_pred_pc),
    .fetch_ready    (fetch_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rob_full_in    (rob_full_in),
    .rs_full_in     (rs_full_in),
    .lsb_full_in    (lsb_full_in),
    .rob_tail_in    (rob_tail_in),
    .reg_id1        (reg_id1),
    .reg_id2        (reg_id2),
    .reg_val1       (reg_val1),
    .reg_val2       (reg_val2),
    .reg_dep1       (reg_dep1),
    .reg_dep2       (reg_dep2),
    .reg_tag1       (reg_tag1),
    .reg_tag2       (reg_tag2),
    .iss            (iss)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_one(input logic [31:0] ins, input logic [XLEN-1:0] pc);
    fetch_valid   = 1'b1;
    fetch_ins     = ins;
    fetch_pc      = pc;
    fetch_pred_pc = pc + 32'd4;
    tick();
    fetch_valid   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; fetch_valid = 1'b0;
    fetch_ins = '0; fetch_pc = '0; fetch_pred_pc = '0;
    rob_full_in = 1'b0; rs_full_in = 1'b0; lsb_full_in = 1'b0; rob_tail_in = '0;
    reg_val1 = '0; reg_val2 = '0; reg_dep1 = 1'b0; reg_dep2 = 1'b0;
    reg_tag1 = '0; reg_tag2 = '0;
    tick(); tick();
    rst_n_in = 1'b1;
    tick();
    total_cnt++;
    if (fetch_ready !== 1'b1) $display("FAIL reset_fetch_ready: got %b want 1", fetch_ready);
    else pass_cnt++;
    total_cnt++;
    if ({iss.rob_valid, iss.rs_valid, iss.lsb_valid, redirect_valid} !== 4'b0000)
      $display("FAIL reset_strobes: got %b want 0000",
               {iss.rob_valid, iss.rs_valid, iss.lsb_valid, redirect_valid});
    else pass_cnt++;
    total_cnt++;
    if (iss.iss_imm !== 32'd0 || iss.iss_pc !== 32'd0 || reg_id1 !== 5'd0)
      $display("FAIL reset_regs: imm=%h pc=%h reg_id1=%0d want all 0",
               iss.iss_imm, iss.iss_pc, reg_id1);
    else pass_cnt++;
  endtask

  task automatic test_addi();
    push_one(INS_ADDI_M5, 32'h0);
    tick();
    total_cnt++;
    if ({iss.rob_valid, iss.rs_valid, iss.lsb_valid} !== 3'b110)
      $display("FAIL addi_strobes: got %b want 110", {iss.rob_valid, iss.rs_valid, iss.lsb_valid});
    else pass_cnt++;
    total_cnt++;
    if (iss.iss_imm !== 32'hFFFFFFFB) $display("FAIL addi_imm: got %h want fffffffb", iss.iss_imm);
    else pass_cnt++;
    total_cnt++;
    if (iss.iss_rd !== 5'd1 || iss.iss_dep1 !== 1'b0 || iss.iss_rs_type !== 6'h10)
      $display("FAIL addi_fields: rd=%0d dep1=%b rs_type=%h want 1 0 10",
               iss.iss_rd, iss.iss_dep1, iss.iss_rs_type);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (iss.rob_valid !== 1'b0) $display("FAIL addi_one_shot: rob_valid=%b want 0", iss.rob_valid);
    else pass_cnt++;
  endtask

  task automatic test_fill_drain();
    logic [XLEN-1:0] pc_list [4];
    rob_full_in = 1'b1;
    for (int i = 0; i < 4; i++) push_one(INS_ADDI_M5, 32'h10 + 32'(4 * i));
    total_cnt++;
    if (fetch_ready !== 1'b0) $display("FAIL full_fetch_ready: got %b want 0", fetch_ready);
    else pass_cnt++;
    total_cnt++;
    if (iss.rob_valid !== 1'b0) $display("FAIL full_no_strobe: rob_valid=%b want 0", iss.rob_valid);
    else pass_cnt++;
    rob_full_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++;
      if (iss.rob_valid !== 1'b1 || iss.iss_pc !== 32'h10 + 32'(4 * i))
        $display("FAIL drain_%0d: rob_valid=%b pc=%h want 1 %h", i, iss.rob_valid, iss.iss_pc,
                 32'h10 + 32'(4 * i));
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if (iss.rob_valid !== 1'b0) $display("FAIL drain_empty: rob_valid=%b want 0", iss.rob_valid);
    else pass_cnt++;

    // Three queued, then a cycle with both push and pop must leave three queued.
    rob_full_in = 1'b1;
    for (int i = 0; i < 3; i++) push_one(INS_ADDI_M5, 32'h20 + 32'(4 * i));
    rob_full_in = 1'b0;
    push_one(INS_ADDI_M5, 32'h2C);
    total_cnt++;
    if (iss.rob_valid !== 1'b1 || iss.iss_pc !== 32'h20)
      $display("FAIL overlap_issue: rob_valid=%b pc=%h want 1 20", iss.rob_valid, iss.iss_pc);
    else pass_cnt++;
    rob_full_in = 1'b1;
    total_cnt++;
    if (fetch_ready !== 1'b1) $display("FAIL overlap_count3: fetch_ready=%b want 1", fetch_ready);
    else pass_cnt++;
    push_one(INS_ADDI_M5, 32'h30);
    total_cnt++;
    if (fetch_ready !== 1'b0) $display("FAIL overlap_count4: fetch_ready=%b want 0", fetch_ready);
    else pass_cnt++;
    rob_full_in = 1'b0;
    pc_list[0] = 32'h24; pc_list[1] = 32'h28; pc_list[2] = 32'h2C; pc_list[3] = 32'h30;
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++;
      if (iss.rob_valid !== 1'b1 || iss.iss_pc !== pc_list[i])
        $display("FAIL overlap_drain_%0d: rob_valid=%b pc=%h want 1 %h", i, iss.rob_valid,
                 iss.iss_pc, pc_list[i]);
      else pass_cnt++;
    end
    tick();
  endtask

  task automatic test_jalr_wait();
    reg_dep1 = 1'b1;
    push_one(INS_JALR, 32'h40);
    push_one(INS_ADDI_M5, 32'h44);
    total_cnt++;
    if (iss.rob_valid !== 1'b0 || reg_id1 !== 5'd5)
      $display("FAIL jalr_wait1: rob_valid=%b reg_id1=%0d want 0 5", iss.rob_valid, reg_id1);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (iss.rob_valid !== 1'b0 || redirect_valid !== 1'b0)
      $display("FAIL jalr_wait2: rob_valid=%b redirect=%b want 0 0", iss.rob_valid, redirect_valid);
    else pass_cnt++;
    reg_dep1 = 1'b0; reg_val1 = 32'h100;
    fetch_valid = 1'b1; fetch_ins = INS_ADDI_M5; fetch_pc = 32'h48; fetch_pred_pc = 32'h4C;
    tick();
    fetch_valid = 1'b0; reg_val1 = '0;
    total_cnt++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h108)
      $display("FAIL jalr_redirect: valid=%b pc=%h want 1 108", redirect_valid, redirect_pc);
    else pass_cnt++;
    total_cnt++;
    if ({iss.rob_valid, iss.rs_valid, iss.lsb_valid} !== 3'b100 || iss.iss_rob_ready !== 1'b1
        || iss.iss_rob_value !== 32'h44)
      $display("FAIL jalr_issue: strobes=%b ready=%b value=%h want 100 1 44",
               {iss.rob_valid, iss.rs_valid, iss.lsb_valid}, iss.iss_rob_ready, iss.iss_rob_value);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (iss.rob_valid !== 1'b0 || redirect_valid !== 1'b0 || fetch_ready !== 1'b1)
      $display("FAIL jalr_discard: rob_valid=%b redirect=%b fetch_ready=%b want 0 0 1",
               iss.rob_valid, redirect_valid, fetch_ready);
    else pass_cnt++;
  endtask

  task automatic test_store_lsb_full();
    lsb_full_in = 1'b1; reg_dep2 = 1'b1; reg_tag2 = 5'd7; rob_tail_in = 5'd9;
    push_one(INS_SW, 32'h50);
    tick();
    total_cnt++;
    if (iss.rob_valid !== 1'b0) $display("FAIL sw_blocked: rob_valid=%b want 0", iss.rob_valid);
    else pass_cnt++;
    lsb_full_in = 1'b0;
    tick();
    reg_dep2 = 1'b0; reg_tag2 = '0;
    total_cnt++;
    if ({iss.rob_valid, iss.rs_valid, iss.lsb_valid} !== 3'b101)
      $display("FAIL sw_strobes: got %b want 101", {iss.rob_valid, iss.rs_valid, iss.lsb_valid});
    else pass_cnt++;
    total_cnt++;
    if (iss.iss_lsb_type !== 4'b1010 || iss.iss_imm !== 32'd12 || iss.iss_rob_type !== ROB_ST)
      $display("FAIL sw_decode: lsb_type=%b imm=%h rob_type=%0d want 1010 c 2",
               iss.iss_lsb_type, iss.iss_imm, iss.iss_rob_type);
    else pass_cnt++;
    total_cnt++;
    if (iss.iss_dep2 !== 1'b1 || iss.iss_q2 !== 5'd7 || iss.iss_rob_id !== 5'd9 || iss.iss_rd !== 5'd0)
      $display("FAIL sw_operands: dep2=%b q2=%0d rob_id=%0d rd=%0d want 1 7 9 0",
               iss.iss_dep2, iss.iss_q2, iss.iss_rob_id, iss.iss_rd);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_decode_mix();
    logic [31:0] ins_tab [3];
    logic [31:0] imm_tab [3];
    logic [4:0]  rd_tab  [3];
    logic        rdy_tab [3];
    logic        rs_tab  [3];
    ins_tab[0] = INS_SRAI;    imm_tab[0] = 32'd3;        rd_tab[0] = 5'd1; rdy_tab[0] = 1'b0; rs_tab[0] = 1'b1;
    ins_tab[1] = INS_LUI;     imm_tab[1] = 32'h12345000; rd_tab[1] = 5'd3; rdy_tab[1] = 1'b1; rs_tab[1] = 1'b0;
    ins_tab[2] = INS_UNKNOWN; imm_tab[2] = 32'd0;        rd_tab[2] = 5'd0; rdy_tab[2] = 1'b1; rs_tab[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) push_one(ins_tab[i], 32'h60 + 32'(4 * i));
      else tick();
      if (i >= 1) begin
        total_cnt++;
        if (iss.rob_valid !== 1'b1 || iss.rs_valid !== rs_tab[i-1] || iss.lsb_valid !== 1'b0
            || iss.iss_rd !== rd_tab[i-1] || iss.iss_rob_ready !== rdy_tab[i-1])
          $display("FAIL mix_%0d: rob=%b rs=%b lsb=%b rd=%0d ready=%b want 1 %b 0 %0d %b", i - 1,
                   iss.rob_valid, iss.rs_valid, iss.lsb_valid, iss.iss_rd, iss.iss_rob_ready,
                   rs_tab[i-1], rd_tab[i-1], rdy_tab[i-1]);
        else pass_cnt++;
        if (i != 3) begin
          total_cnt++;
          if (iss.iss_imm !== imm_tab[i-1])
            $display("FAIL mix_imm_%0d: got %h want %h", i - 1, iss.iss_imm, imm_tab[i-1]);
          else pass_cnt++;
        end
        if (i == 1) begin
          total_cnt++;
          if (iss.iss_rs_type !== 6'h1D)
            $display("FAIL srai_rs_type: got %h want 1d", iss.iss_rs_type);
          else pass_cnt++;
        end
        if (i == 2) begin
          total_cnt++;
          if (iss.iss_rob_value !== 32'h12345000)
            $display("FAIL lui_value: got %h want 12345000", iss.iss_rob_value);
          else pass_cnt++;
        end
      end
    end
  endtask

  task automatic test_rdy_pause();
    push_one(INS_ADDI_M5, 32'h90);
    rdy_in = 1'b0;
    tick(); tick();
    total_cnt++;
    if (iss.rob_valid !== 1'b0 || fetch_ready !== 1'b0)
      $display("FAIL rdy_pause: rob_valid=%b fetch_ready=%b want 0 0", iss.rob_valid, fetch_ready);
    else pass_cnt++;
    rdy_in = 1'b1;
    tick();
    total_cnt++;
    if (iss.rob_valid !== 1'b1 || iss.iss_pc !== 32'h90)
      $display("FAIL rdy_resume: rob_valid=%b pc=%h want 1 90", iss.rob_valid, iss.iss_pc);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_flush();
    push_one(INS_ADDI_M5, 32'hA0);
    flush_in = 1'b1;
    fetch_valid = 1'b1; fetch_ins = INS_ADDI_M5; fetch_pc = 32'hA4; fetch_pred_pc = 32'hA8;
    tick();
    flush_in = 1'b0; fetch_valid = 1'b0;
    total_cnt++;
    if (iss.rob_valid !== 1'b0 || redirect_valid !== 1'b0 || fetch_ready !== 1'b1)
      $display("FAIL flush_edge: rob_valid=%b redirect=%b fetch_ready=%b want 0 0 1",
               iss.rob_valid, redirect_valid, fetch_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (iss.rob_valid !== 1'b0 || reg_id1 !== 5'd0)
      $display("FAIL flush_empty: rob_valid=%b reg_id1=%0d want 0 0", iss.rob_valid, reg_id1);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    push_one(INS_ADDI_M5, 32'h70);
    tick();
    reg_dep1 = 1'b1;
    push_one(INS_JALR, 32'h74);
    tick();
    total_cnt++;
    if (iss.rob_valid !== 1'b0 || iss.iss_pc !== 32'h70)
      $display("FAIL jwait_hold: rob_valid=%b pc=%h want 0 70", iss.rob_valid, iss.iss_pc);
    else pass_cnt++;
    #2 rst_n_in = 1'b0;
    #1;
    total_cnt++;
    if (iss.iss_imm !== 32'd0 || iss.iss_pc !== 32'd0 || fetch_ready !== 1'b0 || reg_id1 !== 5'd0)
      $display("FAIL async_reset: imm=%h pc=%h fetch_ready=%b reg_id1=%0d want 0 0 0 0",
               iss.iss_imm, iss.iss_pc, fetch_ready, reg_id1);
    else pass_cnt++;
    #2 rst_n_in = 1'b1;
    tick();
    total_cnt++;
    if (fetch_ready !== 1'b1) $display("FAIL post_reset_ready: got %b want 1", fetch_ready);
    else pass_cnt++;
    push_one(INS_ADDI_M5, 32'h80);
    tick();
    reg_dep1 = 1'b0;
    total_cnt++;
    if (iss.rob_valid !== 1'b1 || iss.iss_dep1 !== 1'b1 || iss.iss_pc !== 32'h80)
      $display("FAIL post_reset_run: rob_valid=%b dep1=%b pc=%h want 1 1 80",
               iss.rob_valid, iss.iss_dep1, iss.iss_pc);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_fill_drain();
    test_jalr_wait();
    test_store_lsb_full();
    test_decode_mix();
    test_rdy_pause();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
